// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: memory width and exception codes shared with the ROM responder,
// plus the instruction-queue entry type used by the fetch unit.
`ifndef FETCH_SHARED_DEFINES
`define FETCH_SHARED_DEFINES
`define MEM_WIDTH_BYTE 2'b00
`define MEM_WIDTH_HALF 2'b01
`define MEM_WIDTH_WORD 2'b10
`define EXCEPTION_LEN 4
`define EXCEP_OK 4'd0
`define EXCEP_INVALID_MEM_READ 4'd1
`define EXCEP_MISALIGNED_FETCH 4'd2
`endif

package fetch_unit_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, instr} entries with flush; flush wins over push/pop.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end

    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= push_data;

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pipelined instruction fetch with credit-limited queue, redirects and precise faults.
// Optional FETCH_PERF_CNT_EN adds fetchCount_Out, a wrapping count of instructions delivered.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [31:0]               memAddr_Out,
    output logic [1:0]                memDataWidth_Out,
    output logic                      memInputValid_Out,
    input  logic [31:0]               memData_In,
    input  logic                      memOperationOK_In,
    input  logic [`EXCEPTION_LEN-1:0] memException_In,
    input  logic                      redirect_In,
    input  logic [31:0]               redirectPC_In,
    output logic [31:0]               instr_Out,
    output logic [31:0]               instrPC_Out,
    output logic                      instrValid_Out,
    input  logic                      instrReady_In,
    output logic [`EXCEPTION_LEN-1:0] exception_Out,
    output logic [31:0]               faultPC_Out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               fetchCount_Out
`endif
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    typedef enum logic {RUN, FAULT} state_t;
    state_t state, state_n;
    logic [31:0] pc, pend_pc, fault_pc;
    logic [`EXCEPTION_LEN-1:0] exc_code;
    logic [CW-1:0] count;
    logic inflight, discard, issue, req_fault, misaligned, push, pop, drained;
    fetch_entry_t head;

    // Credits count queued words plus the one response that may still be on its way.
    always_comb begin
        misaligned = redirect_In && redirectPC_In[1:0] != 2'b00;
        issue = rst && state == RUN && !redirect_In &&
                ({1'b0, count} + (CW+1)'(inflight) < (CW+1)'(QUEUE_DEPTH));
        req_fault = memException_In != `EXCEP_OK;
        state_n = redirect_In ? (misaligned ? FAULT : RUN) : (issue && req_fault) ? FAULT : state;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= RUN;
        else state <= state_n;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pc       <= RESET_PC;
            pend_pc  <= '0;
            fault_pc <= '0;
            exc_code <= `EXCEP_OK;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            inflight <= issue && !req_fault;
            discard  <= redirect_In ? inflight : issue && req_fault;
            if (redirect_In) begin
                pc <= redirectPC_In;
                if (misaligned) begin
                    exc_code <= `EXCEP_MISALIGNED_FETCH;
                    fault_pc <= redirectPC_In;
                end
            end else if (issue && !req_fault) begin
                pc      <= pc + 32'd4;
                pend_pc <= pc;
            end else if (issue) begin
                exc_code <= memException_In;
                fault_pc <= pc;
            end
        end

    assign push = memOperationOK_In && inflight && !discard && !redirect_In;
    assign pop  = instrValid_Out && instrReady_In;

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ('{pc: pend_pc, instr: memData_In}),
        .pop       (pop),
        .flush     (redirect_In),
        .head      (head),
        .count     (count)
    );

    // Fault is only reported once every older instruction has left the unit.
    assign drained           = state == FAULT && count == '0 && !inflight;
    assign exception_Out     = drained ? exc_code : `EXCEP_OK;
    assign faultPC_Out       = drained ? fault_pc : '0;
    assign instrValid_Out    = count != '0;
    assign instr_Out         = instrValid_Out ? head.instr : '0;
    assign instrPC_Out       = instrValid_Out ? head.pc : '0;
    assign memAddr_Out       = pc;
    assign memDataWidth_Out  = `MEM_WIDTH_WORD;
    assign memInputValid_Out = issue;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) fetchCount_Out <= '0;
        else if (pop) fetchCount_Out <= fetchCount_Out + 32'd1;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit against a 64KiB ROM model returning addr as data.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [31:0] memAddr_Out;
    logic [1:0] memDataWidth_Out;
    logic memInputValid_Out;
    logic [31:0] memData_In = '0;
    logic memOperationOK_In = 1'b0;
    logic [`EXCEPTION_LEN-1:0] memException_In;
    logic redirect_In = 1'b0;
    logic [31:0] redirectPC_In = '0;
    logic [31:0] instr_Out, instrPC_Out;
    logic instrValid_Out;
    logic instrReady_In = 1'b0;
    logic [`EXCEPTION_LEN-1:0] exception_Out;
    logic [31:0] faultPC_Out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCount_Out;
`endif
    int checks = 0, fails = 0, req_cnt = 0, pops = 0, snap = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .memAddr_Out       (memAddr_Out),
        .memDataWidth_Out  (memDataWidth_Out),
        .memInputValid_Out (memInputValid_Out),
        .memData_In        (memData_In),
        .memOperationOK_In (memOperationOK_In),
        .memException_In   (memException_In),
        .redirect_In       (redirect_In),
        .redirectPC_In     (redirectPC_In),
        .instr_Out         (instr_Out),
        .instrPC_Out       (instrPC_Out),
        .instrValid_Out    (instrValid_Out),
        .instrReady_In     (instrReady_In),
        .exception_Out     (exception_Out),
        .faultPC_Out       (faultPC_Out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetchCount_Out    (fetchCount_Out)
`endif
    );

    // ROM responder: one-cycle latency, reads at or above 64KiB are rejected combinationally.
    assign memException_In = (memAddr_Out >= 32'h0001_0000) ? `EXCEP_INVALID_MEM_READ : `EXCEP_OK;
    always @(posedge clk) begin
        memOperationOK_In <= memInputValid_Out;
        memData_In        <= memAddr_Out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        instrReady_In = 1'b1;
        while (sb.size() != 0 && k < 200) begin
            cyc(1);
            k++;
        end
        instrReady_In = 1'b0;
        chk("drain_remaining", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_instrValid"}, 32'(instrValid_Out), 32'd0);
        chk({tag, "_instr"}, instr_Out, 32'd0);
        chk({tag, "_instrPC"}, instrPC_Out, 32'd0);
        chk({tag, "_memValid"}, 32'(memInputValid_Out), 32'd0);
        chk({tag, "_memAddr"}, memAddr_Out, 32'd0);
        chk({tag, "_memWidth"}, 32'(memDataWidth_Out), 32'(`MEM_WIDTH_WORD));
        chk({tag, "_exception"}, 32'(exception_Out), 32'(`EXCEP_OK));
        chk({tag, "_faultPC"}, faultPC_Out, 32'd0);
    endtask

    always @(negedge clk) if (memInputValid_Out) req_cnt++;

    // Monitor: every accepted handshake is checked against the oldest expected word.
    always @(negedge clk)
        if (rst && instrValid_Out) begin
            chk("precise_while_valid", 32'(exception_Out), 32'(`EXCEP_OK));
            if (instrReady_In) begin
                pops++;
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pop: got pc %h, expected no delivery", instrPC_Out);
                end else begin
                    exp_pc = sb.pop_front();
                    chk("instrPC", instrPC_Out, exp_pc);
                    chk("instr", instr_Out, exp_pc);
                end
            end
        end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks + 1, fails + 1);
        $fatal(1);
    end

    initial begin
        #2;
        chk_reset_outputs("reset");
        expect_run(32'h0, 8);
        cyc(1);
        rst = 1'b1;
        @(negedge clk);
        chk("first_req_valid", 32'(memInputValid_Out), 32'd1);
        chk("first_req_addr", memAddr_Out, 32'h0);
        cyc(1);
        wait_empty();

        cyc(4);
        snap = req_cnt;
        cyc(6);
        chk("stall_no_requests", 32'(req_cnt - snap), 32'd0);
        chk("stall_valid_held", 32'(instrValid_Out), 32'd1);
        expect_run(32'h20, 4);
        wait_empty();

        cyc(6);
        expect_run(32'h30, 1);
        instrReady_In = 1'b1;
        cyc(1);
        instrReady_In = 1'b0;
        @(negedge clk);
        chk("inflight_req_valid", 32'(memInputValid_Out), 32'd1);
        chk("inflight_req_addr", memAddr_Out, 32'h38);
        cyc(1);
        redirect_In = 1'b1;
        redirectPC_In = 32'h100;
        cyc(1);
        redirect_In = 1'b0;
        expect_run(32'h100, 4);
        wait_empty();

        redirect_In = 1'b1;
        redirectPC_In = 32'hFFF0;
        cyc(1);
        redirect_In = 1'b0;
        expect_run(32'hFFF0, 4);
        wait_empty();
        for (int k = 0; k < 20 && exception_Out == `EXCEP_OK; k++) cyc(1);
        chk("fault_code", 32'(exception_Out), 32'(`EXCEP_INVALID_MEM_READ));
        chk("fault_pc", faultPC_Out, 32'h0001_0000);
        chk("fault_queue_empty", 32'(instrValid_Out), 32'd0);
        snap = req_cnt;
        cyc(5);
        chk("fault_halts_issue", 32'(req_cnt - snap), 32'd0);
        chk("fault_pc_held", memAddr_Out, 32'h0001_0000);

        redirect_In = 1'b1;
        redirectPC_In = 32'h102;
        snap = req_cnt;
        cyc(1);
        redirect_In = 1'b0;
        @(negedge clk);
        chk("misaligned_code", 32'(exception_Out), 32'(`EXCEP_MISALIGNED_FETCH));
        chk("misaligned_pc", faultPC_Out, 32'h102);
        cyc(4);
        chk("misaligned_no_requests", 32'(req_cnt - snap), 32'd0);
        redirect_In = 1'b1;
        redirectPC_In = 32'h200;
        cyc(1);
        redirect_In = 1'b0;
        chk("fault_cleared", 32'(exception_Out), 32'(`EXCEP_OK));
        expect_run(32'h200, 4);
        wait_empty();

        redirect_In = 1'b1;
        redirectPC_In = 32'h300;
        cyc(1);
        redirect_In = 1'b0;
        cyc(2);
        chk("pre_reset_valid", 32'(instrValid_Out), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        sb.delete();
        pops = 0;
        #1;
        rst = 1'b1;
        expect_run(32'h0, 4);
        wait_empty();
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetchCount_Out, 32'(pops));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
